data_bus_arbiter: RTL and testbench



---
 rtl/data_bus_pkg.sv | 10 +
 rtl/data_bus_arbiter_rr_pick2.sv | 13 +
 rtl/data_bus_arbiter.sv | 97 +++++++++
 tb/tb_data_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared types and constants for the data bus arbiter
package data_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
endpackage

// File: rtl/data_bus_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker, the requester not named by ptr wins a tie
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       valid
);
  // a lone requester wins; on contention the one that was not served last wins
  always_comb begin
    grant = &req ? ~ptr : req[1];
    valid = |req;
  end
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin sharing of data_bus between m0 and m1, one transaction at a time
module data_bus_arbiter import data_bus_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write,
  input  logic [DATA_W-1:0] bus_read,
  input  logic              bus_exception,
  output logic              busy
);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_bus_arbiter: LATENCY must be within 1..15");
  end
  state_t     state;
  logic       ptr;
  logic       owner;
  logic [3:0] cnt;
  logic       grant;
  logic       valid;
  rr_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .ptr   (ptr),
    .grant (grant),
    .valid (valid)
  );
  assign busy = state != IDLE;
  // transaction FSM: latch winner in IDLE, hold bus for LATENCY cycles, ack in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= M1;
      owner     <= M0;
      cnt       <= '0;
      bus_rw    <= 1'b0;
      bus_addr  <= '0;
      bus_write <= '0;
      m0_ack    <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_ack    <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      bus_rw <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          owner     <= grant;
          bus_rw    <= grant ? m1_rw : m0_rw;
          bus_addr  <= grant ? m1_addr : m0_addr;
          bus_write <= grant ? m1_wdata : m0_wdata;
          cnt       <= 4'(LATENCY - 1);
          state     <= ACCESS;
        end
        ACCESS: if (cnt == 4'd0) begin
          if (owner == M1) begin
            m1_rdata <= bus_read;
            m1_err   <= bus_exception;
            m1_ack   <= 1'b1;
          end else begin
            m0_rdata <= bus_read;
            m0_err   <= bus_exception;
            m0_ack   <= 1'b1;
          end
          state <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          ptr   <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: scoreboard bench, dut a at LATENCY=1 and dut b at LATENCY=3 on shared requester inputs
module tb_data_bus_arbiter;
  import data_bus_pkg::*;
  localparam logic [63:0] KEY = 64'hDEAD_BFEF;
  typedef struct packed {
    logic       idx;
    logic       err;
    logic [63:0] rdata;
    logic [7:0] lat;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0;
  logic [63:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic bus_exception = 1'b0;
  logic a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_bus_rw, a_busy;
  logic [63:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_write, a_bus_read;
  logic b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_bus_rw, b_busy;
  logic [63:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_write, b_bus_read;
  logic [261:0] a_outs, b_outs;
  rec_t sb[$];
  int checks = 0;
  int failures = 0;
  assign a_bus_read = a_bus_addr ^ KEY;
  assign b_bus_read = b_bus_addr ^ KEY;
  assign a_outs = {a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_bus_rw, a_busy, a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_write};
  assign b_outs = {b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_bus_rw, b_busy, b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_write};
  always #5 clk = ~clk;
  data_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
    .bus_rw(a_bus_rw), .bus_addr(a_bus_addr), .bus_write(a_bus_write),
    .bus_read(a_bus_read), .bus_exception(bus_exception), .busy(a_busy)
  );
  data_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
    .bus_rw(b_bus_rw), .bus_addr(b_bus_addr), .bus_write(b_bus_write),
    .bus_read(b_bus_read), .bus_exception(bus_exception), .busy(b_busy)
  );
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {m0_req, m0_rw, m1_req, m1_rw, bus_exception} = '0;
    {m0_addr, m1_addr, m0_wdata, m1_wdata} = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic collect(input bit use_b, output rec_t o, output bit ok);
    ok = 1'b0;
    o = '0;
    for (int n = 1; n <= 40 && !ok; n++) begin
      @(negedge clk);
      if (use_b ? (b_m0_ack | b_m1_ack) : (a_m0_ack | a_m1_ack)) begin
        ok = 1'b1;
        o.idx = use_b ? b_m1_ack : a_m1_ack;
        o.err = use_b ? (b_m1_ack ? b_m1_err : b_m0_err) : (a_m1_ack ? a_m1_err : a_m0_err);
        o.rdata = use_b ? (b_m1_ack ? b_m1_rdata : b_m0_rdata) : (a_m1_ack ? a_m1_rdata : a_m0_rdata);
        o.lat = 8'(n);
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_outs, b_outs} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got a=%h b=%h exp all zero", a_outs, b_outs);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_busy, b_busy, a_bus_rw, b_bus_rw} !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b%b rw=%b%b exp 0", a_busy, b_busy, a_bus_rw, b_bus_rw);
    end
  endtask
  task automatic test_single_read();
    rec_t o, e;
    bit ok;
    do_reset();
    m0_req = 1'b1; m0_rw = RW_READ; m0_addr = 64'h100;
    sb.push_back('{idx: M0, err: 1'b0, rdata: 64'hDEAD_BEEF, lat: 8'd2});
    collect(1'b0, o, ok);
    m0_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!ok || o !== e) begin
      failures++;
      $display("FAIL single_read got ok=%0d rec=%h exp rec=%h", ok, o, e);
    end
    checks++;
    if (a_m1_rdata !== 64'h0 || a_m1_err !== 1'b0) begin
      failures++;
      $display("FAIL single_read_m1_untouched got rdata=%h err=%b exp 0", a_m1_rdata, a_m1_err);
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_m0_ack !== 1'b0 || a_m0_rdata !== 64'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_read_after got busy=%b ack=%b rdata=%h exp 0 0 deadbeef", a_busy, a_m0_ack, a_m0_rdata);
    end
  endtask
  task automatic test_write_strobe();
    rec_t o, e;
    logic [3:0] rw_pat = '0, ack_pat = '0, m0_pat = '0;
    int addr_ok = 0;
    logic [63:0] wr = '0;
    do_reset();
    m1_req = 1'b1; m1_rw = RW_WRITE; m1_addr = 64'h40; m1_wdata = 64'h5A;
    sb.push_back('{idx: M1, err: 1'b0, rdata: 64'h40 ^ KEY, lat: 8'd4});
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      rw_pat = {rw_pat[2:0], b_bus_rw};
      ack_pat = {ack_pat[2:0], b_m1_ack};
      m0_pat = {m0_pat[2:0], b_m0_ack};
      if (n <= 3 && b_bus_addr === 64'h40) addr_ok++;
      if (n == 1) wr = b_bus_write;
      if (b_m1_ack) o = '{idx: M1, err: b_m1_err, rdata: b_m1_rdata, lat: 8'(n)};
    end
    m1_req = 1'b0;
    checks++;
    if (rw_pat !== 4'b1000) begin
      failures++;
      $display("FAIL write_strobe_rw got %b exp 1000", rw_pat);
    end
    checks++;
    if (addr_ok != 3 || wr !== 64'h5A) begin
      failures++;
      $display("FAIL write_strobe_addr got addr_cycles=%0d wdata=%h exp 3 5a", addr_ok, wr);
    end
    checks++;
    if (ack_pat !== 4'b0001 || m0_pat !== 4'b0000) begin
      failures++;
      $display("FAIL write_strobe_ack got m1=%b m0=%b exp 0001 0000", ack_pat, m0_pat);
    end
    e = sb.pop_front();
    checks++;
    if (ack_pat[0] !== 1'b1 || o !== e) begin
      failures++;
      $display("FAIL write_strobe_resp got rec=%h exp rec=%h", o, e);
    end
  endtask
  task automatic test_back_to_back();
    rec_t o, e;
    bit ok;
    do_reset();
    m0_req = 1'b1; m0_addr = 64'h1000;
    m1_req = 1'b1; m1_addr = 64'h2000;
    for (int i = 0; i < 4; i++)
      sb.push_back('{idx: i[0], err: 1'b0, rdata: (i[0] ? 64'h2000 : 64'h1000) ^ KEY, lat: (i == 0) ? 8'd2 : 8'd3});
    for (int i = 0; i < 4; i++) begin
      collect(1'b0, o, ok);
      if (i == 3) {m0_req, m1_req} = 2'b00;
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) begin
        failures++;
        $display("FAIL contention_%0d got ok=%0d rec=%h exp rec=%h", i, ok, o, e);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL contention_idle got busy=%b acks=%b%b exp 0", a_busy, a_m0_ack, a_m1_ack);
    end
  endtask
  task automatic test_exception();
    rec_t o, e;
    bit ok;
    do_reset();
    m0_req = 1'b1; m0_addr = 64'h300; bus_exception = 1'b1;
    sb.push_back('{idx: M0, err: 1'b1, rdata: 64'h300 ^ KEY, lat: 8'd2});
    sb.push_back('{idx: M0, err: 1'b0, rdata: 64'h308 ^ KEY, lat: 8'd2});
    for (int i = 0; i < 2; i++) begin
      collect(1'b0, o, ok);
      m0_req = 1'b0;
      bus_exception = 1'b0;
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) begin
        failures++;
        $display("FAIL exception_%0d got ok=%0d rec=%h exp rec=%h", i, ok, o, e);
      end
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 64'h308;
    end
    m0_req = 1'b0;
  endtask
  task automatic test_withdrawn();
    rec_t o, e;
    bit ok;
    do_reset();
    m1_req = 1'b1; m1_addr = 64'h80;
    sb.push_back('{idx: M1, err: 1'b0, rdata: 64'h80 ^ KEY, lat: 8'd1});
    @(negedge clk);
    m1_req = 1'b0; m1_addr = 64'hFFF;
    collect(1'b0, o, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || o !== e) begin
      failures++;
      $display("FAIL req_withdrawn got ok=%0d rec=%h exp rec=%h", ok, o, e);
    end
  endtask
  task automatic test_reset_midop();
    rec_t o, e;
    bit ok;
    do_reset();
    m0_req = 1'b1; m0_addr = 64'h500; m0_rw = RW_WRITE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_outs, b_outs} !== '0) begin
      failures++;
      $display("FAIL reset_midop_outputs got a=%h b=%h exp all zero", a_outs, b_outs);
    end
    reset = 1'b0; m0_rw = RW_READ;
    m1_req = 1'b1; m1_addr = 64'h600;
    sb.push_back('{idx: M0, err: 1'b0, rdata: 64'h500 ^ KEY, lat: 8'd2});
    collect(1'b0, o, ok);
    {m0_req, m1_req} = 2'b00;
    e = sb.pop_front();
    checks++;
    if (!ok || o !== e) begin
      failures++;
      $display("FAIL reset_midop_first_grant got ok=%0d rec=%h exp rec=%h", ok, o, e);
    end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_write_strobe();
    test_back_to_back();
    test_exception();
    test_withdrawn();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
